// File: rtl/paddsb_seq_pkg.sv
// Shared constants and FSM encoding for the sub-word saturating adder.
package paddsb_seq_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int DATA_W = LANES * LANE_W;
  localparam int CNT_W  = 2;

  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [LANE_W-1:0] SAT_POS   = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG   = 4'h8;

  // Unused code 2'b11 is steered back to IDLE by the next-state logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/paddsb_seq_sat_add_4bit.sv
// 4-bit ripple adder and the signed saturating lane adder built on it.

module add_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;

  // Plain full-adder ripple chain, LSB to MSB.
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign sum[g]     = a[g] ^ b[g] ^ w_c[g];
    assign w_c[g + 1] = (a[g] & b[g]) | (a[g] & w_c[g]) | (b[g] & w_c[g]);
  end

  assign cout = w_c[4];
endmodule

module sat_add_4bit
  import paddsb_seq_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum,
  output logic              ovf
);
  logic [LANE_W-1:0] w_raw;
  logic              w_cout;

  add_4bit u_add (
    .a    (a),
    .b    (b),
    .cin  (1'b0),
    .sum  (w_raw),
    .cout (w_cout)
  );

  // Signed overflow: operands share a sign and the result sign differs.
  // When that happens the carry-out equals the shared operand sign, so it
  // selects the clamp direction (cout=1 means both negative).
  always_comb begin
    ovf = (a[3] == b[3]) && (w_raw[3] != a[3]);
    sum = w_raw;
    if (ovf) begin
      sum = w_cout ? SAT_NEG : SAT_POS;
    end
  end
endmodule

// File: rtl/paddsb_seq.sv
// Multi-cycle PADDSB: four independent signed 4-bit lanes, saturated,
// computed through one shared lane adder, lane 0 first.
//
// Handshake: start is sampled only while idle (busy=0); an accepted start
// latches A/B and raises busy on the next cycle. busy stays high through the
// one-cycle done pulse; Sum/ovf are valid on done and hold until the next
// accepted start. start while busy is dropped, not queued.
module paddsb_seq
  import paddsb_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Sum,
  output logic [LANES-1:0]  ovf,
  output state_t            dbg_state
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_sum;
  logic [LANES-1:0]   r_ovf;
  logic [LANE_W-1:0]  w_lane_a;
  logic [LANE_W-1:0]  w_lane_b;
  logic [LANE_W-1:0]  w_lane_sum;
  logic               w_lane_ovf;

  // Lane mux: pick the operand nibbles selected by the lane counter.
  assign w_lane_a = r_a[r_cnt * LANE_W +: LANE_W];
  assign w_lane_b = r_b[r_cnt * LANE_W +: LANE_W];

  sat_add_4bit u_lane (
    .a   (w_lane_a),
    .b   (w_lane_b),
    .sum (w_lane_sum),
    .ovf (w_lane_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = start ? CALC : IDLE;
      CALC:    w_next_state = (r_cnt == LAST_LANE) ? DONE : CALC;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      CALC: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, lane counter and per-lane write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_ovf <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_cnt <= '0;
            r_sum <= '0;
            r_ovf <= '0;
          end
        end
        CALC: begin
          r_sum[r_cnt * LANE_W +: LANE_W] <= w_lane_sum;
          r_ovf[r_cnt]                    <= w_lane_ovf;
          r_cnt                           <= r_cnt + 1'b1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign Sum       = r_sum;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_paddsb_seq.sv
// Self-checking bench for paddsb_seq: directed cases plus randomized ops
// checked against an integer-arithmetic saturating-add model.
module tb_paddsb_seq;
  import paddsb_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Sum;
  logic [3:0]  ovf;
  state_t      dbg_state;

  int n_tests;
  int n_fail;
  logic [19:0] exp_q[$];

  paddsb_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Sum       (Sum),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each lane is a signed nibble; add as integers and clamp.
  function automatic logic [19:0] ref_paddsb(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [3:0]  o;
    s = '0;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      int x;
      int y;
      int r;
      x = int'($signed(a[i*4 +: 4]));
      y = int'($signed(b[i*4 +: 4]));
      r = x + y;
      if (r > 7) begin
        s[i*4 +: 4] = 4'h7;
        o[i] = 1'b1;
      end else if (r < -8) begin
        s[i*4 +: 4] = 4'h8;
        o[i] = 1'b1;
      end else begin
        s[i*4 +: 4] = r[3:0];
      end
    end
    return {o, s};
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: start pulse in cycle N, scramble inputs afterwards, watch for
  // done (bounded), and return one cycle after done (back in IDLE).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] s,
                       output logic [3:0] o, output logic busy_ok);
    A = a;
    B = b;
    start = 1'b1;
    lat = -1;
    s = '0;
    o = '0;
    busy_ok = 1'b1;
    step();
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    for (int k = 1; k <= 10; k++) begin
      if (lat < 0) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (done === 1'b1) begin
          lat = k;
          s = Sum;
          o = ovf;
        end
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = 16'hFFFF;
    B = 16'hFFFF;
    repeat (3) step();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, Sum, ovf} !== 22'h0 || dbg_state !== IDLE) begin
      $display("FAIL reset_state: busy=%b done=%b Sum=%h ovf=%h state=%0d want all zero/IDLE",
               busy, done, Sum, ovf, dbg_state);
      n_fail++;
    end
  endtask

  task automatic test_plain_add();
    int lat;
    logic [15:0] s;
    logic [3:0] o;
    logic bok;
    do_op(16'h1234, 16'h1111, lat, s, o, bok);
    n_tests++;
    if (lat !== 5) begin
      $display("FAIL plain_latency: got %0d want 5", lat);
      n_fail++;
    end
    n_tests++;
    if ({o, s} !== {4'h0, 16'h2345}) begin
      $display("FAIL plain_result: got Sum=%h ovf=%h want 2345/0", s, o);
      n_fail++;
    end
    n_tests++;
    if (bok !== 1'b1) begin
      $display("FAIL plain_busy: busy low during N+1..N+5, want high");
      n_fail++;
    end
    // Now in N+6: idle, result held.
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || Sum !== 16'h2345 || ovf !== 4'h0) begin
      $display("FAIL plain_hold: busy=%b done=%b Sum=%h ovf=%h want 0/0/2345/0",
               busy, done, Sum, ovf);
      n_fail++;
    end
    step();
    n_tests++;
    if (Sum !== 16'h2345) begin
      $display("FAIL plain_hold2: Sum=%h want 2345", Sum);
      n_fail++;
    end
  endtask

  task automatic test_directed(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] es, input logic [3:0] eo);
    int lat;
    logic [15:0] s;
    logic [3:0] o;
    logic bok;
    do_op(a, b, lat, s, o, bok);
    n_tests++;
    if (lat !== 5 || {o, s} !== {eo, es}) begin
      $display("FAIL directed_%h_%h: lat=%0d Sum=%h ovf=%h want lat=5 Sum=%h ovf=%h",
               a, b, lat, s, o, es, eo);
      n_fail++;
    end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] a, b, s;
    logic [3:0] o;
    logic bok;
    logic [19:0] exp;
    for (int t = 0; t < 24; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp_q.push_back(ref_paddsb(a, b));
      do_op(a, b, lat, s, o, bok);
      exp = exp_q.pop_front();
      n_tests++;
      if (lat !== 5 || {o, s} !== exp || bok !== 1'b1) begin
        $display("FAIL random_%0d: A=%h B=%h lat=%0d busy_ok=%b got %h/%h want %h/%h",
                 t, a, b, lat, bok, o, s, exp[19:16], exp[15:0]);
        n_fail++;
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_start_while_busy();
    logic [19:0] e1, e2;
    int ndone;
    int at;
    logic [19:0] got;
    e1 = ref_paddsb(16'h3A5C, 16'h4B21);
    e2 = ref_paddsb(16'h1357, 16'h2468);
    A = 16'h3A5C; B = 16'h4B21; start = 1'b1;    // N
    step(); start = 1'b0;                        // N+1
    step(); A = 16'h1357; B = 16'h2468; start = 1'b1;  // N+2
    step(); start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;  // N+3
    step();                                      // N+4
    step();                                      // N+5
    n_tests++;
    if (done !== 1'b1 || {ovf, Sum} !== e1) begin
      $display("FAIL busy_first: done=%b got %h/%h want 1 %h/%h",
               done, ovf, Sum, e1[19:16], e1[15:0]);
      n_fail++;
    end
    step();                                      // N+6
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL busy_idle: done=%b busy=%b want 0/0", done, busy);
      n_fail++;
    end
    A = 16'h1357; B = 16'h2468; start = 1'b1;
    step(); start = 1'b0;
    ndone = 0;
    at = 0;
    got = '0;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) begin
        ndone++;
        at = k;
        got = {ovf, Sum};
      end
      step();
    end
    n_tests++;
    if (ndone !== 1 || at !== 5 || got !== e2) begin
      $display("FAIL busy_second: pulses=%0d at=%0d got %h want 1 pulse at 5 with %h",
               ndone, at, got, e2);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    logic [15:0] s;
    logic [3:0] o;
    logic bok;
    A = 16'h7777; B = 16'h1111; start = 1'b1;    // N
    step(); start = 1'b0;                        // N+1
    step(); rst = 1'b1;                          // N+2
    step(); rst = 1'b0;                          // N+3
    n_tests++;
    if ({busy, done, Sum, ovf} !== 22'h0 || dbg_state !== IDLE) begin
      $display("FAIL reset_mid: busy=%b done=%b Sum=%h ovf=%h want all zero",
               busy, done, Sum, ovf);
      n_fail++;
    end
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      step();
    end
    n_tests++;
    if (ndone !== 0) begin
      $display("FAIL reset_mid_quiet: %0d busy/done cycles after reset, want 0", ndone);
      n_fail++;
    end
    do_op(16'h7F12, 16'h1F13, lat, s, o, bok);
    n_tests++;
    if (lat !== 5 || {o, s} !== {4'h8, 16'h7E25}) begin
      $display("FAIL reset_mid_next: lat=%0d Sum=%h ovf=%h want 5 7E25/8", lat, s, o);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] a, b, s;
    logic [3:0] o;
    logic bok;
    for (int t = 0; t < 4; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp_q.push_back(ref_paddsb(a, b));
      do_op(a, b, lat, s, o, bok);
      n_tests++;
      if (lat !== 5 || {o, s} !== exp_q.pop_front()) begin
        $display("FAIL b2b_%0d: A=%h B=%h lat=%0d got %h/%h", t, a, b, lat, o, s);
        n_fail++;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    test_reset();
    test_plain_add();
    test_directed(16'h7777, 16'h1111, 16'h7777, 4'hF);
    test_directed(16'h8888, 16'h8888, 16'h8888, 4'hF);
    test_directed(16'h7F12, 16'h1F13, 16'h7E25, 4'h8);
    test_directed(16'h8000, 16'hF000, 16'h8000, 4'h8);
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/paddsb_seq.md
Name: paddsb_seq

Overview:
- Multi-cycle sub-word parallel adder (PADDSB): the inverse-direction companion to the 16-bit nibble reduction unit.
- The reduction unit collapses four nibbles into one sum. This block keeps the four nibble lanes independent and saturates each lane to signed 4-bit.
- Reuses one 4-bit adder slice, one lane per cycle, LSB lane first.
- Sits beside the ALU in EX. The pipeline stalls on busy and captures Sum on done.

Parameters:
- LANES, 4, number of sub-word lanes.
- LANE_W, 4, lane width in bits. Data width = LANES*LANE_W = 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  16  operand A, LANES signed 4-bit lanes.
- B  in  16  operand B, same format.
- busy  out  1  high while operands are held and lanes are computing.
- done  out  1  one-cycle pulse; Sum and ovf valid.
- Sum  out  16  per-lane saturated result.
- ovf  out  4  per-lane saturation flag; bit i = lane i [4i+3:4i].

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0; done=0; Sum=16'h0000; ovf=4'h0; lane counter=0; operand registers cleared. Reset has priority over every other event, including mid-operation; a partial result is discarded.
- States:
  - IDLE: start=1 -> latch A,B into internal regs, clear Sum/ovf accumulators, counter=0, go to CALC. start=0 -> stay; Sum/ovf hold the last result.
  - CALC: each edge commits lane[counter] into Sum and ovf, then counter++. At counter=LANES-1 the commit happens and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Cycle latency: start high in cycle N -> lanes committed at the ends of N+1..N+4 -> done=1 in cycle N+5 -> IDLE in N+6.
  - A new start is accepted in N+6 at the earliest.
  - Back-to-back throughput is one op per 6 cycles.
- busy=1 in CALC and DONE; 0 in IDLE. busy is registered, rising in cycle N+1.
- start while busy is ignored (not queued). A and B changes while busy have no effect, because the operands are latched.
- Sum and ovf are registered and hold their value from done until the next accepted start. During CALC they show partially updated lanes; consumers sample only on done.
- Lane arithmetic, per lane, signed two's complement 4-bit:
  - raw = a+b via 4-bit ripple adder, cin=0.
  - Overflow when a[3]==b[3] and raw[3]!=a[3].
  - Positive overflow -> 4'h7, negative overflow -> 4'h8, else raw.
  - ovf[i] = overflow.
  - No carry crosses lanes.

Decomposition:
- Shared package holds:
  - constants LANES=4, LANE_W=4, SAT_POS=4'h7, SAT_NEG=4'h8;
  - the FSM state encoding IDLE=2'b00, CALC=2'b01, DONE=2'b10. Any unused code goes to IDLE.
- One sub-module: sat_add_4bit. It is combinational: a, b 4-bit in; sum 4-bit and ovf out. It is built around the existing add_4bit ripple adder, with cin tied 0.
- The top level holds the FSM, the counter, the operand registers and the lane mux and write-back.

Test Plan:
- Plain add: A=16'h1234, B=16'h1111, start pulse -> done in cycle N+5, Sum=16'h2345, ovf=4'h0, busy high in N+1..N+5.
- Positive saturation: A=16'h7777, B=16'h1111 -> Sum=16'h7777, ovf=4'hF.
- Negative saturation: A=16'h8888, B=16'h8888 -> Sum=16'h8888, ovf=4'hF.
- Mixed lanes, no inter-lane carry: A=16'h7F12, B=16'h1F13 -> Sum=16'h7E25, ovf=4'h8.
- Start while busy: start in N, second start with different operands in N+2 -> single done in N+5 with the first result; no second done; start in N+6 accepted.
- Reset mid-operation: start in N, rst=1 in N+2 -> from N+3: busy=0, done=0, Sum=16'h0000, ovf=4'h0; no done pulse; next start behaves normally.
